// File: rtl/dmem_pkg.sv
// Shared constants for the data-memory responder: default widths,
// MMIO register addresses, FSM state encoding and read-source selects.
package dmem_pkg;

  localparam int DMEM_ADDR_WIDTH = 12;
  localparam int DMEM_DATA_WIDTH = 32;

  localparam logic [11:0] MMIO_LED    = 12'hFFC;
  localparam logic [11:0] MMIO_STORES = 12'hFFD;
  localparam logic [11:0] MMIO_CYCLES = 12'hFFE;
  localparam logic [11:0] MMIO_STATUS = 12'hFFF;

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  // Which source drives q_dmem for the access registered on the last edge
  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_MMIO = 2'd2;

endpackage

// File: rtl/dmem_ram_sp.sv
// Single-port synchronous RAM with a registered, write-first read port.
module dmem_ram_sp #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4092
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Write the addressed word and return the new data on the same edge
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
      rdata     <= wdata;
    end else begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: word RAM below MMIO_BASE plus an MMIO window
// (LED, store counter, cycle counter, status) at the top of the space.
// Optional build macro DMEM_CLEAR_ON_RESET_EN zero-fills the RAM after reset.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int                    ADDR_WIDTH = DMEM_ADDR_WIDTH,
  parameter int                    DATA_WIDTH = DMEM_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0] MMIO_BASE  = ADDR_WIDTH'(12'hFFC)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address_dmem,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q_dmem,
  output logic                  ready,
  output logic [DATA_WIDTH-1:0] led_out,
  output logic [31:0]           store_count
);

  logic [0:0]            state;
  logic [0:0]            state_next;
  logic                  clear_last;
  logic [31:0]           cycle_count;
  logic [1:0]            rd_sel;
  logic [DATA_WIDTH-1:0] mmio_q;
  logic [DATA_WIDTH-1:0] mmio_next;
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic                  in_ram;
  logic                  store_ok;

  assign in_ram   = (address_dmem < MMIO_BASE);
  assign store_ok = wren && (state == S_READY);

`ifdef DMEM_CLEAR_ON_RESET_EN
  localparam logic [0:0] RESET_STATE = S_CLEAR;

  logic [ADDR_WIDTH-1:0] clear_ptr;

  assign clear_last = (state == S_CLEAR) && (clear_ptr == MMIO_BASE - ADDR_WIDTH'(1));

  // Walk the clear pointer across the RAM while in CLEAR
  always_ff @(posedge clock) begin
    if (reset) begin
      clear_ptr <= '0;
    end else if (state == S_CLEAR) begin
      clear_ptr <= clear_ptr + ADDR_WIDTH'(1);
    end
  end

  // RAM port: clear writes take over the port, otherwise the core owns it
  always_comb begin
    ram_we    = store_ok && in_ram;
    ram_addr  = address_dmem;
    ram_wdata = data;
    if (state == S_CLEAR) begin
      ram_we    = 1'b1;
      ram_addr  = clear_ptr;
      ram_wdata = '0;
    end
  end
`else
  localparam logic [0:0] RESET_STATE = S_READY;

  assign clear_last = 1'b0;

  // RAM port driven directly by the core
  always_comb begin
    ram_we    = store_ok && in_ram;
    ram_addr  = address_dmem;
    ram_wdata = data;
  end
`endif

  // Next FSM state: CLEAR hands over to READY after its last word
  always_comb begin
    state_next = state;
    if (state == S_CLEAR && clear_last) begin
      state_next = S_READY;
    end
  end

  // MMIO read value as it should appear after this edge (write-first LED)
  always_comb begin
    mmio_next = '0;
    case (address_dmem)
      ADDR_WIDTH'(MMIO_LED):    mmio_next = store_ok ? data : led_out;
      ADDR_WIDTH'(MMIO_STORES): mmio_next = DATA_WIDTH'(store_count);
      ADDR_WIDTH'(MMIO_CYCLES): mmio_next = DATA_WIDTH'(cycle_count);
      ADDR_WIDTH'(MMIO_STATUS): mmio_next = {{(DATA_WIDTH-1){1'b0}}, ready};
      default:                  mmio_next = '0;
    endcase
  end

  // FSM, counters, LED register and registered read-source select
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RESET_STATE;
      ready       <= 1'b0;
      led_out     <= '0;
      store_count <= '0;
      cycle_count <= '0;
      rd_sel      <= SEL_ZERO;
      mmio_q      <= '0;
    end else begin
      state       <= state_next;
      ready       <= (state_next == S_READY);
      cycle_count <= cycle_count + 32'd1;
      mmio_q      <= mmio_next;
      if (store_ok) begin
        store_count <= store_count + 32'd1;
        if (address_dmem == ADDR_WIDTH'(MMIO_LED)) begin
          led_out <= data;
        end
      end
      if (state == S_CLEAR) begin
        rd_sel <= SEL_ZERO;
      end else if (in_ram) begin
        rd_sel <= SEL_RAM;
      end else begin
        rd_sel <= SEL_MMIO;
      end
    end
  end

  // Load data: RAM word, MMIO value, or zero after reset / during clear
  always_comb begin
    q_dmem = '0;
    case (rd_sel)
      SEL_RAM:  q_dmem = ram_q;
      SEL_MMIO: q_dmem = mmio_q;
      default:  q_dmem = '0;
    endcase
  end

  dmem_ram_sp #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (int'(MMIO_BASE))
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_q)
  );

endmodule
